// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared types and constants for the truth-table sweeper.
// Optional feature macro: TT_SWEEP_CHECK_EN (adds on-chip expected-column
// comparison in tt_sweep).
package tt_sweep_pkg;

  // Vector index width and number of input vectors of a 3-input function
  localparam int VEC_W   = 3;
  localparam int NUM_VEC = 8;

  // Default number of cycles each vector is held before it is sampled
  localparam int SETTLE_CYCLES_DEF = 2;

  // Settle counter width covers the legal hold range 1..15
  localparam int CNT_W = 4;

  // Mismatch counter width covers 0..2*NUM_VEC
  localparam int ERR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Value loaded into the count-down timer so that it expires after
  // exactly 'cycles' cycles of counting (expire fires when it reads zero).
  function automatic logic [CNT_W-1:0] settle_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: loadable count-down timer that times the hold of one
// input vector. expire_o is high during the last cycle of the hold.
module tt_settle_timer
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic run_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] LOAD_VAL = settle_load(SETTLE_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load has priority, otherwise count down while running
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/tt_sweep.sv
// tt_sweep: drives all 8 input vectors of a 3-input combinational block,
// waits SETTLE_CYCLES per vector, and captures the two fed-back outputs
// into truth-table columns (bit i = value for vector i).
// Optional feature macro: TT_SWEEP_CHECK_EN adds exp_s1/exp_s2 inputs,
// a running mismatch counter err_cnt and a pass flag.
module tt_sweep
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               s1,
  input  logic               s2,
`ifdef TT_SWEEP_CHECK_EN
  input  logic [NUM_VEC-1:0] exp_s1,
  input  logic [NUM_VEC-1:0] exp_s2,
  output logic [ERR_W-1:0]   err_cnt,
  output logic               pass,
`endif
  output logic               x,
  output logic               y,
  output logic               z,
  output logic               busy,
  output logic               done,
  output logic [NUM_VEC-1:0] result_s1,
  output logic [NUM_VEC-1:0] result_s2
);

  state_e state_q;
  state_e state_d;

  logic [VEC_W-1:0]   idx_q;
  logic [VEC_W-1:0]   idx_d;
  logic [NUM_VEC-1:0] res1_q;
  logic [NUM_VEC-1:0] res1_d;
  logic [NUM_VEC-1:0] res2_q;
  logic [NUM_VEC-1:0] res2_d;
  logic [NUM_VEC-1:0] cap_hit;
  logic [VEC_W-1:0]   vec;

  logic start_acc;
  logic cap_edge;
  logic last_vec;
  logic timer_load;
  logic timer_run;
  logic settle_expire;

  // Start is only honoured while not sweeping; capture happens on the
  // single CAPTURE cycle of each vector.
  assign start_acc  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign cap_edge   = (state_q == ST_CAPTURE);
  assign last_vec   = (idx_q == VEC_W'(NUM_VEC - 1));

  // The timer is (re)armed whenever a DRIVE phase is about to begin
  assign timer_load = start_acc || (cap_edge && !last_vec);
  assign timer_run  = (state_q == ST_DRIVE);

  tt_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (timer_load),
    .run_i    (timer_run),
    .expire_o (settle_expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (settle_expire) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = last_vec ? ST_DONE : ST_DRIVE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state; the vector is only presented while
  // sweeping so the block under test sees 000 when idle.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    vec  = '0;
    unique case (state_q)
      ST_DRIVE, ST_CAPTURE: begin
        busy = 1'b1;
        vec  = idx_q;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign {x, y, z} = vec;

  // Vector index: reset to 0 on start, advance after each non-final capture
  always_comb begin
    idx_d = idx_q;
    if (start_acc) begin
      idx_d = '0;
    end else if (cap_edge && !last_vec) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Per-bit result capture: a column bit only changes when its own vector
  // is captured, and the whole column clears on start acceptance.
  for (genvar gi = 0; gi < NUM_VEC; gi++) begin : g_cap
    assign cap_hit[gi] = cap_edge && (idx_q == VEC_W'(gi));
    assign res1_d[gi]  = start_acc ? 1'b0 : (cap_hit[gi] ? s1 : res1_q[gi]);
    assign res2_d[gi]  = start_acc ? 1'b0 : (cap_hit[gi] ? s2 : res2_q[gi]);
  end

  // Index and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      res1_q <= '0;
      res2_q <= '0;
    end else begin
      idx_q  <= idx_d;
      res1_q <= res1_d;
      res2_q <= res2_d;
    end
  end

  assign result_s1 = res1_q;
  assign result_s2 = res2_q;

`ifdef TT_SWEEP_CHECK_EN
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;

  // Mismatch accumulation: at most 2 per vector, so 5 bits never overflow
  always_comb begin
    err_d = err_q;
    if (start_acc) begin
      err_d = '0;
    end else if (cap_edge) begin
      err_d = err_q + ERR_W'(s1 != exp_s1[idx_q]) + ERR_W'(s2 != exp_s2[idx_q]);
    end
  end

  // Mismatch counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
  assign pass    = done && (err_q == '0);
`endif

endmodule

// File: doc/tt_sweep.md
TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, cycles each input vector is held before its outputs are sampled; legal range 1..15.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 start  input  1  sweep request; sampled only in IDLE and DONE.
REQ-005 x, y, z  output  1 each  drive the downstream 3-input combinational function under test.
REQ-006 s1, s2  input  1 each  outputs of the function under test, fed back for capture.
REQ-007 busy  output  1  high in DRIVE and CAPTURE.
REQ-008 done  output  1  high in DONE.
REQ-009 result_s1, result_s2  output  8 each  captured truth-table columns; bit i is the value for vector i.
REQ-010 With TT_SWEEP_CHECK_EN only: exp_s1, exp_s2  input  8 each  expected columns; err_cnt  output  5  mismatch count; pass  output  1  high when done is high and err_cnt is 0.

Function
REQ-011 The FSM SHALL have four states: IDLE, DRIVE, CAPTURE and DONE.
REQ-012 Vector index idx SHALL be 3 bits, and {x,y,z} SHALL equal idx with x as the MSB whenever the state is DRIVE or CAPTURE; in IDLE and DONE, x, y and z SHALL be 0.
REQ-013 IDLE: start=1 SHALL set idx=0, clear the settle counter, clear the results and move to DRIVE on the same edge.
REQ-014 DRIVE SHALL last exactly SETTLE_CYCLES cycles and then move to CAPTURE.
REQ-015 CAPTURE SHALL last one cycle; at its closing edge, result_s1[idx] SHALL take s1 and result_s2[idx] SHALL take s2.
REQ-016 At the CAPTURE closing edge, idx=7 SHALL move to DONE; otherwise idx SHALL increment and the FSM SHALL return to DRIVE (no wrap-around of idx).
REQ-017 Latency: done SHALL rise exactly 8*(SETTLE_CYCLES+1) cycles after the start-accepting edge (24 cycles at the default).
REQ-018 DONE SHALL hold done and the results until start or rst; start in DONE SHALL behave as in IDLE (restart with cleared results).
REQ-019 start while busy SHALL be ignored, with no effect on idx, the counter or the results.
REQ-020 Results SHALL change only at CAPTURE edges, on start acceptance and on rst.

Reset
REQ-021 rst=1 at any edge, including mid-sweep, SHALL force IDLE, idx=0, counter=0, x=y=z=0, busy=0, done=0, results=0, err_cnt=0 and pass=0; rst SHALL take priority over start.
REQ-022 The first start after rst is released SHALL begin a full sweep at vector 0.

Configuration
REQ-023 Macro TT_SWEEP_CHECK_EN, when defined, SHALL add exp_s1, exp_s2, err_cnt and pass.
REQ-024 With TT_SWEEP_CHECK_EN, at each CAPTURE edge err_cnt SHALL add (s1!=exp_s1[idx]) + (s2!=exp_s2[idx]), with range 0..16 and no saturation needed.
REQ-025 With TT_SWEEP_CHECK_EN, err_cnt SHALL clear on start acceptance.
REQ-026 Without TT_SWEEP_CHECK_EN, those ports and that logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-027 Package tt_sweep_pkg SHALL hold the state enum, VEC_W=3, NUM_VEC=8 and the SETTLE_CYCLES default.
REQ-028 One sub-module, tt_settle_timer (load, count-down, expire pulse), SHALL implement the DRIVE hold; the FSM, index and capture logic SHALL remain in tt_sweep.

Verification
REQ-029 Golden function s1=s2=~x&y, SETTLE_CYCLES=2, start pulse: done SHALL rise at cycle 24 with result_s1=result_s2=8'h0C; with the check macro, err_cnt=0 and pass=1.
REQ-030 With the check macro, same DUT and exp_s1=8'h0D, exp_s2=8'h0C: err_cnt=1 and pass=0 when done rises.
REQ-031 rst asserted at cycle 10 of a sweep: on the next edge all outputs SHALL be 0 and the state IDLE; a subsequent start SHALL complete normally in 24 cycles.
REQ-032 start held high through a whole sweep: exactly one sweep SHALL occur; in DONE the still-high start SHALL restart, with results reading 0 on the following cycle.
REQ-033 SETTLE_CYCLES=1: the vector sequence 000..111 SHALL appear on {x,y,z}, each held for 2 cycles, with done at cycle 16.
REQ-034 With the function under test forced to s1=1 and s2=0: result_s1=8'hFF and result_s2=8'h00; with exp=8'h0C for both and the check macro, err_cnt=8.
